instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 13 +
 rtl/instr_fetch_if.sv | 43 ++++
 rtl/instr_fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared core constants for the instruction fetch stage: datapath width,
// sequential PC increment and the fetch FSM state encoding.
package instr_fetch_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_INC      = 4;

    typedef logic [0:0] fetch_state_t;

    localparam fetch_state_t ST_RUN   = 1'b0;
    localparam fetch_state_t ST_DRAIN = 1'b1;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch stage bus: instruction memory request/response, decode handoff and
// redirect from the branch unit. The fetch unit is the master side.
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int W = INSTR_WIDTH
);

    logic         redirect_i;
    logic [W-1:0] redirect_pc_i;

    logic         imem_req_o;
    logic [W-1:0] imem_addr_o;
    logic         imem_gnt_i;
    logic         imem_rvalid_i;
    logic [W-1:0] imem_rdata_i;

    logic         instr_valid_o;
    logic [W-1:0] instr_o;
    logic [W-1:0] instr_pc_o;
    logic         instr_ready_i;

    logic [W-1:0] new_pc_o;

    modport master (
        input  redirect_i, redirect_pc_i,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_ready_i,
        output imem_req_o, imem_addr_o,
        output instr_valid_o, instr_o, instr_pc_o,
        output new_pc_o
    );

    modport slave (
        output redirect_i, redirect_pc_i,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_ready_i,
        input  imem_req_o, imem_addr_o,
        input  instr_valid_o, instr_o, instr_pc_o,
        input  new_pc_o
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small circular FIFO used twice by the fetch stage: once for the in-order
// record of granted addresses, once for {instruction, pc} awaiting decode.
// Flush wins over push/pop. A push is accepted while full if a pop happens
// in the same cycle (the head is read before the edge overwrites it).
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy flags and qualified push/pop.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem[rd_ptr];
    end

    // Entry storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word-aligned sequential requests to
// instruction memory, pairs in-order responses with their addresses and
// hands them to decode, and flushes/restarts on a redirect.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_RUN   | normal fetch: request, collect responses, feed decode
//   ST_DRAIN | after redirect: swallow responses of the old stream, no
//            | requests; back to ST_RUN once discard_cnt hits zero
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                        REG_DATA_WIDTH = INSTR_WIDTH,
    parameter logic [REG_DATA_WIDTH-1:0] BOOT_ADDR      = 32'h0000_0000,
    parameter int                        DEPTH          = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam int W  = REG_DATA_WIDTH;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = CW + 1;

    localparam logic [W-1:0]  PC_MASK    = ~W'(3);
    localparam logic [W-1:0]  BOOT_ALIGN = BOOT_ADDR & PC_MASK;
    localparam logic [CW:0]   DEPTH_L    = (CW + 1)'(DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [W-1:0]  fetch_pc;
    logic [DW-1:0] discard_cnt;
    logic [DW-1:0] discard_nxt;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] buffered;
    logic          trk_empty;
    logic [W-1:0]  trk_head;

    logic          ifq_empty;
    logic [2*W-1:0] ifq_head;
    logic          ifq_push;
    logic          ifq_pop;

    logic          redirect;
    logic          room;
    logic          grant_hit;
    logic          fire_grant;
    logic          rvalid_run;
    logic          fire_resp;
    logic          resp_hit;

    assign redirect = bus.redirect_i;

    // Request qualification and handshake decode. grant_hit is evaluated
    // without the redirect mask so that a memory grant landing in the
    // redirect cycle is still counted as in flight and later discarded.
    always_comb begin
        room       = ({1'b0, outstanding} + {1'b0, buffered}) < DEPTH_L;
        grant_hit  = (state == ST_RUN) && room && bus.imem_gnt_i;
        fire_grant = grant_hit && !redirect;
        // Responses with nothing recorded (e.g. left over across reset) are ignored.
        rvalid_run = (state == ST_RUN) && bus.imem_rvalid_i && !trk_empty;
        fire_resp  = rvalid_run && !redirect;
        resp_hit   = bus.imem_rvalid_i &&
                     ((state == ST_RUN) ? !trk_empty : (discard_cnt != '0));
    end

    // Memory request port; held low through reset and during redirect.
    always_comb begin
        bus.imem_req_o  = rst_n && (state == ST_RUN) && room && !redirect;
        bus.imem_addr_o = fetch_pc;
        bus.new_pc_o    = fetch_pc;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_addr_trk (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (fire_grant),
        .wdata (fetch_pc),
        .pop   (fire_resp),
        .rdata (trk_head),
        .empty (trk_empty),
        .count (outstanding)
    );

    // Decode handoff: FIFO head when buffered, otherwise bypass the response
    // straight through; only unconsumed responses are written.
    always_comb begin
        ifq_pop  = !ifq_empty && bus.instr_ready_i && !redirect;
        ifq_push = fire_resp && !(ifq_empty && bus.instr_ready_i);
        bus.instr_valid_o = !redirect && (!ifq_empty || rvalid_run);
        if (ifq_empty) begin
            bus.instr_o    = bus.imem_rdata_i;
            bus.instr_pc_o = trk_head;
        end else begin
            bus.instr_o    = ifq_head[2*W-1:W];
            bus.instr_pc_o = ifq_head[W-1:0];
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * W)
    ) u_instr_q (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (ifq_push),
        .wdata ({bus.imem_rdata_i, trk_head}),
        .pop   (ifq_pop),
        .rdata (ifq_head),
        .empty (ifq_empty),
        .count (buffered)
    );

    // Next state and discard count. On redirect everything still in flight
    // (recorded, already being discarded, or granted this cycle) minus any
    // response arriving now must be swallowed.
    always_comb begin
        state_nxt   = state;
        discard_nxt = discard_cnt;
        if (redirect) begin
            discard_nxt = DW'(outstanding) + discard_cnt + DW'(grant_hit) - DW'(resp_hit);
            state_nxt   = (discard_nxt != '0) ? ST_DRAIN : ST_RUN;
        end else if (state == ST_DRAIN) begin
            if (resp_hit) begin
                discard_nxt = discard_cnt - DW'(1);
            end
            if (discard_nxt == '0) begin
                state_nxt = ST_RUN;
            end
        end
    end

    // FSM state and discard counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            discard_cnt <= '0;
        end else begin
            state       <= state_nxt;
            discard_cnt <= discard_nxt;
        end
    end

    // Fetch PC: redirect target (word aligned) or sequential advance on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= BOOT_ALIGN;
        end else if (redirect) begin
            fetch_pc <= bus.redirect_pc_i & PC_MASK;
        end else if (fire_grant) begin
            fetch_pc <= fetch_pc + W'(PC_INC);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a behavioural instruction memory with a
// grant budget and optional response hold, expected request addresses and
// decode deliveries queued by the directed sequence, and monitors that pop
// and compare whenever the DUT presents a grant or a delivery.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    instr_fetch_if #(.W(32)) bus ();

    instr_fetch #(
        .REG_DATA_WIDTH (32),
        .BOOT_ADDR      (32'h0000_0000),
        .DEPTH          (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_addr [$];
    logic [63:0] exp_ins  [$];
    logic [31:0] pend     [$];

    int grant_cnt   = 0;
    int grant_limit = 0;
    bit resp_hold   = 1'b0;
    bit force_stale = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F69;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit deliver);
        exp_addr.push_back(a);
        if (deliver) exp_ins.push_back({mem_word(a), a});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_addr.size() != 0 || exp_ins.size() != 0 || grant_cnt != grant_limit) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL %s timeout: %0d addr and %0d instr expectations left, grants %0d of %0d",
                     name, exp_addr.size(), exp_ins.size(), grant_cnt, grant_limit);
            exp_addr.delete();
            exp_ins.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_grants(input string name, input int target);
        int n = 0;
        while (grant_cnt < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL %s grant timeout: got %0d grants, required %0d", name, grant_cnt, target);
        end
    endtask

    // Instruction memory: grants within budget, in-order responses no sooner
    // than the cycle after grant, and reset together with the DUT.
    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
            end else if (bus.imem_gnt_i && (bus.imem_req_o || force_stale)) begin
                pend.push_back(bus.imem_addr_o);
                grant_cnt++;
            end
            @(posedge clk);
            #1;
            if (rst_n && !resp_hold && pend.size() > 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mem_word(pend.pop_front());
            end else begin
                bus.imem_rvalid_i = 1'b0;
            end
            bus.imem_gnt_i = (grant_cnt < grant_limit);
        end
    end

    // Monitor: request addresses at accepted handshakes, decode deliveries.
    initial begin
        logic [31:0] ea;
        logic [63:0] ei;
        forever begin
            @(negedge clk);
            if (rst_n && bus.imem_req_o && bus.imem_gnt_i) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_request", {32'h0, bus.imem_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ea = exp_addr.pop_front();
                    check("request_addr", {32'h0, bus.imem_addr_o}, {32'h0, ea});
                    check("new_pc_at_grant", {32'h0, bus.new_pc_o}, {32'h0, ea});
                end
            end
            if (rst_n && bus.instr_valid_o && bus.instr_ready_i) begin
                if (exp_ins.size() == 0) begin
                    check("unexpected_delivery", {bus.instr_o, bus.instr_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ei = exp_ins.pop_front();
                    check("delivery_instr_pc", {bus.instr_o, bus.instr_pc_o}, ei);
                end
            end
        end
    end

    initial begin
        int start;
        rst_n             = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req",      {63'h0, bus.imem_req_o},    64'h0);
        check("reset_valid",    {63'h0, bus.instr_valid_o}, 64'h0);
        check("reset_new_pc",   {32'h0, bus.new_pc_o},      64'h0);

        // Streaming from BOOT_ADDR, grant every cycle, 1-cycle response.
        for (int i = 0; i < 6; i++) expect_fetch(32'(4 * i), 1'b1);
        grant_limit = grant_cnt + 6;
        step();
        rst_n = 1'b1;
        wait_drain("stream");
        check("stream_new_pc", {32'h0, bus.new_pc_o}, 64'h18);

        // Decode stalled: only DEPTH grants, then resume with no loss.
        step();
        bus.instr_ready_i = 1'b0;
        start = grant_cnt;
        for (int i = 0; i < 10; i++) expect_fetch(32'h18 + 32'(4 * i), 1'b1);
        grant_limit = grant_cnt + 10;
        repeat (8) @(negedge clk);
        check("stall_grants",   64'(grant_cnt),            64'(start + 2));
        check("stall_req_low",  {63'h0, bus.imem_req_o},   64'h0);
        check("stall_head",     {bus.instr_valid_o, 31'h0, bus.instr_pc_o}, {1'b1, 31'h0, 32'h18});
        step();
        bus.instr_ready_i = 1'b1;
        wait_drain("stall_release");

        // Redirect to a misaligned target with two requests outstanding.
        step();
        resp_hold = 1'b1;
        expect_fetch(32'h40, 1'b0);
        expect_fetch(32'h44, 1'b0);
        grant_limit = grant_cnt + 2;
        wait_grants("pre_redirect", grant_limit);
        @(negedge clk);
        step();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_1002;
        for (int i = 0; i < 3; i++) expect_fetch(32'h1000 + 32'(4 * i), 1'b1);
        grant_limit = grant_cnt + 3;
        @(negedge clk);
        check("redirect_req_low",   {63'h0, bus.imem_req_o},    64'h0);
        check("redirect_valid_low", {63'h0, bus.instr_valid_o}, 64'h0);
        step();
        bus.redirect_i = 1'b0;
        resp_hold      = 1'b0;
        @(negedge clk);
        check("drain_req_low", {63'h0, bus.imem_req_o}, 64'h0);
        check("drain_new_pc",  {32'h0, bus.new_pc_o},   64'h1000);
        wait_drain("redirect_drain");

        // Redirect coinciding with a grant and a response of the old stream.
        step();
        start = grant_cnt;
        expect_fetch(32'h100C, 1'b1);
        expect_fetch(32'h1010, 1'b1);
        expect_fetch(32'h1014, 1'b0);
        grant_limit = grant_cnt + 10;
        wait_grants("stream_before_redirect", start + 3);
        step();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_2000;
        force_stale       = 1'b1;
        grant_limit       = grant_cnt + 3;
        expect_fetch(32'h2000, 1'b1);
        expect_fetch(32'h2004, 1'b1);
        @(negedge clk);
        check("collide_valid_low", {63'h0, bus.instr_valid_o}, 64'h0);
        step();
        bus.redirect_i = 1'b0;
        force_stale    = 1'b0;
        @(negedge clk);
        check("collide_drain_req_low", {63'h0, bus.imem_req_o}, 64'h0);
        wait_drain("collide");

        // Address wrap past 0xFFFF_FFFC.
        step();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFF8;
        expect_fetch(32'hFFFF_FFF8, 1'b1);
        expect_fetch(32'hFFFF_FFFC, 1'b1);
        expect_fetch(32'h0000_0000, 1'b1);
        grant_limit = grant_cnt + 3;
        step();
        bus.redirect_i = 1'b0;
        wait_drain("wrap");
        check("wrap_new_pc", {32'h0, bus.new_pc_o}, 64'h4);

        // Reset with the decode FIFO full.
        step();
        bus.instr_ready_i = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_3000;
        expect_fetch(32'h3000, 1'b0);
        expect_fetch(32'h3004, 1'b0);
        grant_limit = grant_cnt + 2;
        step();
        bus.redirect_i = 1'b0;
        wait_grants("fill", grant_limit);
        repeat (3) @(negedge clk);
        check("full_head",    {bus.instr_valid_o, 31'h0, bus.instr_pc_o}, {1'b1, 31'h0, 32'h3000});
        check("full_req_low", {63'h0, bus.imem_req_o}, 64'h0);
        step();
        rst_n = 1'b0;
        #1;
        check("midreset_valid",  {63'h0, bus.instr_valid_o}, 64'h0);
        check("midreset_req",    {63'h0, bus.imem_req_o},    64'h0);
        check("midreset_new_pc", {32'h0, bus.new_pc_o},      64'h0);
        bus.instr_ready_i = 1'b1;
        expect_fetch(32'h0, 1'b1);
        expect_fetch(32'h4, 1'b1);
        grant_limit = grant_cnt + 2;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_drain("after_reset");
        check("after_reset_new_pc", {32'h0, bus.new_pc_o}, 64'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
